memory_access_stage: RTL and testbench

//  Pipeline stage directly downstream of the execute stage. It registers the EX/MEM boundary
//  (ALU result, store data, control word) and performs loads/stores over a req/gnt/rvalid

---
 rtl/memory_access_stage_pkg.sv | 35 +++
 rtl/memory_access_stage_load_store_align.sv | 54 +++++
 rtl/memory_access_stage.sv | 221 ++++++++++++++++++++++
 tb/tb_memory_access_stage.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/memory_access_stage_pkg.sv
// Shared types for the memory access stage: FSM states, funct3 access sizes
// and the control word carried from execute through to writeback.
package memory_access_stage_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned F3_W   = 3;
  localparam int unsigned BE_W   = DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RSP  = 2'd2
  } mem_state_t;

  // Load encodings; stores reuse the low three codes.
  typedef enum logic [F3_W-1:0] {
    SZ_LB  = 3'b000,
    SZ_LH  = 3'b001,
    SZ_LW  = 3'b010,
    SZ_LBU = 3'b100,
    SZ_LHU = 3'b101
  } mem_size_t;

  localparam mem_size_t SZ_SB = SZ_LB;
  localparam mem_size_t SZ_SH = SZ_LH;
  localparam mem_size_t SZ_SW = SZ_LW;

  typedef struct packed {
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
    logic [F3_W-1:0] funct3;
  } control_t;

endpackage

// File: rtl/memory_access_stage_load_store_align.sv
// load_store_align: combinational lane steering for the data bus.
//  funct3, addr_lo      : access size and byte offset
//  wdata / wdata_c      : store data in, replicated into byte lanes out
//  be_c                 : byte enables
//  rdata / rdata_ext_c  : raw load word in, aligned and extended value out
//  misaligned_c         : half on odd address or word on non-zero offset
module load_store_align
  import memory_access_stage_pkg::*;
(
  input  logic [F3_W-1:0]   funct3,
  input  logic [1:0]        addr_lo,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] rdata,
  output logic [BE_W-1:0]   be_c,
  output logic [DATA_W-1:0] wdata_c,
  output logic [DATA_W-1:0] rdata_ext_c,
  output logic              misaligned_c
);

  logic [DATA_W-1:0] shifted;

  // Store side: enables and replicated store data.
  always_comb begin
    be_c         = 4'b1111;
    wdata_c      = wdata;
    misaligned_c = 1'b0;
    unique case (funct3[1:0])
      2'b00: begin
        be_c    = 4'b0001 << addr_lo;
        wdata_c = {4{wdata[7:0]}};
      end
      2'b01: begin
        be_c         = 4'b0011 << addr_lo;
        wdata_c      = {2{wdata[15:0]}};
        misaligned_c = addr_lo[0];
      end
      default: misaligned_c = (addr_lo != 2'b00);
    endcase
  end

  // Load side: bring the addressed byte/half down to bit 0, then extend.
  always_comb begin
    shifted     = rdata >> {addr_lo, 3'b000};
    rdata_ext_c = shifted;
    case (funct3)
      SZ_LB:   rdata_ext_c = {{24{shifted[7]}}, shifted[7:0]};
      SZ_LH:   rdata_ext_c = {{16{shifted[15]}}, shifted[15:0]};
      SZ_LBU:  rdata_ext_c = {24'd0, shifted[7:0]};
      SZ_LHU:  rdata_ext_c = {16'd0, shifted[15:0]};
      default: rdata_ext_c = shifted;
    endcase
  end

endmodule

// File: rtl/memory_access_stage.sv
// memory_access_stage: EX/MEM register plus load/store sequencing over a
// req/gnt/rvalid data bus, producing the MEM/WB result.
//  clk, reset (sync, active-high)
//  ex_valid, control_in, alu_data, memory_data : instruction from execute
//  stall, ex_mem_data                          : upstream hold / forwarding value
//  dmem_*                                      : data memory bus
//  wb_valid, control_out, wb_data              : retiring instruction
//  misaligned, bus_error                       : exception pulses with wb_valid
module memory_access_stage
  import memory_access_stage_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ex_valid,
  input  control_t          control_in,
  input  logic [31:0]       alu_data,
  input  logic [31:0]       memory_data,
  output logic              stall,
  output logic [31:0]       ex_mem_data,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [3:0]        dmem_be,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [31:0]       dmem_wdata,
  input  logic              dmem_gnt,
  input  logic              dmem_rvalid,
  input  logic [31:0]       dmem_rdata,
  output logic              wb_valid,
  output control_t          control_out,
  output logic [31:0]       wb_data,
  output logic              misaligned,
  output logic              bus_error
);

  localparam int unsigned CNT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned TO_LAST = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

  mem_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  control_t          ctl_q, ctl_d;
  logic [31:0]       ex_mem_data_q, ex_mem_data_d;
  logic              stall_q, stall_d;
  logic              dmem_req_q, dmem_req_d;
  logic              dmem_we_q, dmem_we_d;
  logic [3:0]        dmem_be_q, dmem_be_d;
  logic [ADDR_W-1:0] dmem_addr_q, dmem_addr_d;
  logic [31:0]       dmem_wdata_q, dmem_wdata_d;
  logic              wb_valid_q, wb_valid_d;
  control_t          control_out_q, control_out_d;
  logic [31:0]       wb_data_q, wb_data_d;
  logic              misaligned_q, misaligned_d;
  logic              bus_error_q, bus_error_d;

  logic [2:0]  sel_f3;
  logic [1:0]  sel_lo;
  logic [3:0]  be_c;
  logic [31:0] wdata_c, rdata_ext_c;
  logic        mis_c, timeout_hit, retire;
  control_t    ret_ctl;
  logic [31:0] ret_data;

  // In IDLE the aligner looks at the incoming instruction; otherwise at the held one.
  always_comb begin
    sel_f3 = ctl_q.funct3;
    sel_lo = ex_mem_data_q[1:0];
    if (state_q == IDLE) begin
      sel_f3 = control_in.funct3;
      sel_lo = alu_data[1:0];
    end
  end

  load_store_align u_align (
    .funct3       (sel_f3),
    .addr_lo      (sel_lo),
    .wdata        (memory_data),
    .rdata        (dmem_rdata),
    .be_c         (be_c),
    .wdata_c      (wdata_c),
    .rdata_ext_c  (rdata_ext_c),
    .misaligned_c (mis_c)
  );

  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_W'(TO_LAST));

  // Next-state and registered-output logic.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    ctl_d         = ctl_q;
    ex_mem_data_d = ex_mem_data_q;
    stall_d       = 1'b0;
    dmem_req_d    = dmem_req_q;
    dmem_we_d     = dmem_we_q;
    dmem_be_d     = dmem_be_q;
    dmem_addr_d   = dmem_addr_q;
    dmem_wdata_d  = dmem_wdata_q;
    wb_valid_d    = 1'b0;
    control_out_d = control_out_q;
    wb_data_d     = wb_data_q;
    misaligned_d  = 1'b0;
    bus_error_d   = 1'b0;
    retire        = 1'b0;
    ret_ctl       = ctl_q;
    ret_data      = ex_mem_data_q;

    unique case (state_q)
      IDLE: begin
        if (ex_valid) begin
          ctl_d         = control_in;
          ex_mem_data_d = alu_data;
          ret_ctl       = control_in;
          ret_data      = alu_data;
          if (!(control_in.mem_read || control_in.mem_write)) begin
            retire = 1'b1;
          end else if (mis_c) begin
            retire       = 1'b1;
            misaligned_d = 1'b1;
          end else begin
            state_d      = REQ;
            cnt_d        = '0;
            dmem_req_d   = 1'b1;
            dmem_we_d    = control_in.mem_write;
            dmem_be_d    = be_c;
            dmem_addr_d  = ADDR_W'({alu_data[31:2], 2'b00});
            dmem_wdata_d = wdata_c;
          end
        end
      end
      REQ: begin
        if (dmem_gnt) begin
          dmem_req_d = 1'b0;
          cnt_d      = '0;
          if (ctl_q.mem_write) retire = 1'b1;
          else                 state_d = RSP;
        end else if (timeout_hit) begin
          retire      = 1'b1;
          bus_error_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RSP: begin
        if (dmem_rvalid) begin
          retire   = 1'b1;
          ret_data = rdata_ext_c;
        end else if (timeout_hit) begin
          retire      = 1'b1;
          bus_error_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Faulted instructions must not write the register file.
    if (retire) begin
      state_d                 = IDLE;
      dmem_req_d              = 1'b0;
      wb_valid_d              = 1'b1;
      control_out_d           = ret_ctl;
      control_out_d.reg_write = ret_ctl.reg_write & ~(misaligned_d | bus_error_d);
      wb_data_d               = ret_data;
    end

    stall_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      ctl_q         <= '0;
      ex_mem_data_q <= '0;
      stall_q       <= 1'b0;
      dmem_req_q    <= 1'b0;
      dmem_we_q     <= 1'b0;
      dmem_be_q     <= '0;
      dmem_addr_q   <= '0;
      dmem_wdata_q  <= '0;
      wb_valid_q    <= 1'b0;
      control_out_q <= '0;
      wb_data_q     <= '0;
      misaligned_q  <= 1'b0;
      bus_error_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      ctl_q         <= ctl_d;
      ex_mem_data_q <= ex_mem_data_d;
      stall_q       <= stall_d;
      dmem_req_q    <= dmem_req_d;
      dmem_we_q     <= dmem_we_d;
      dmem_be_q     <= dmem_be_d;
      dmem_addr_q   <= dmem_addr_d;
      dmem_wdata_q  <= dmem_wdata_d;
      wb_valid_q    <= wb_valid_d;
      control_out_q <= control_out_d;
      wb_data_q     <= wb_data_d;
      misaligned_q  <= misaligned_d;
      bus_error_q   <= bus_error_d;
    end
  end

  assign stall       = stall_q;
  assign ex_mem_data = ex_mem_data_q;
  assign dmem_req    = dmem_req_q;
  assign dmem_we     = dmem_we_q;
  assign dmem_be     = dmem_be_q;
  assign dmem_addr   = dmem_addr_q;
  assign dmem_wdata  = dmem_wdata_q;
  assign wb_valid    = wb_valid_q;
  assign control_out = control_out_q;
  assign wb_data     = wb_data_q;
  assign misaligned  = misaligned_q;
  assign bus_error   = bus_error_q;

endmodule

// File: tb/tb_memory_access_stage.sv
// Randomized bench for memory_access_stage with a reference model of the
// access rules (sizes, lanes, extension, latencies, timeout) built from
// plain arithmetic on byte offsets and sizes.
module tb_memory_access_stage;
  import memory_access_stage_pkg::*;

  localparam int unsigned TO    = 4;
  localparam int unsigned NEVER = 1000;

  logic        clk;
  logic        reset;
  logic        ex_valid;
  control_t    control_in;
  logic [31:0] alu_data;
  logic [31:0] memory_data;
  logic        stall;
  logic [31:0] ex_mem_data;
  logic        dmem_req;
  logic        dmem_we;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        wb_valid;
  control_t    control_out;
  logic [31:0] wb_data;
  logic        misaligned;
  logic        bus_error;

  int n_cmp = 0;
  int n_err = 0;

  logic [2:0] ld_f3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

  memory_access_stage #(.ADDR_W(32), .TIMEOUT(TO)) dut (
    .clk         (clk),
    .reset       (reset),
    .ex_valid    (ex_valid),
    .control_in  (control_in),
    .alu_data    (alu_data),
    .memory_data (memory_data),
    .stall       (stall),
    .ex_mem_data (ex_mem_data),
    .dmem_req    (dmem_req),
    .dmem_we     (dmem_we),
    .dmem_be     (dmem_be),
    .dmem_addr   (dmem_addr),
    .dmem_wdata  (dmem_wdata),
    .dmem_gnt    (dmem_gnt),
    .dmem_rvalid (dmem_rvalid),
    .dmem_rdata  (dmem_rdata),
    .wb_valid    (wb_valid),
    .control_out (control_out),
    .wb_data     (wb_data),
    .misaligned  (misaligned),
    .bus_error   (bus_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic control_t mk_ctl(input logic rw, input logic mr, input logic mw,
                                      input logic [2:0] f3);
    control_t c;
    c.reg_write = rw;
    c.mem_read  = mr;
    c.mem_write = mw;
    c.funct3    = f3;
    return c;
  endfunction

  // Reference model: access size in bytes and its consequences.
  function automatic int unsigned size_of(input logic [2:0] f3);
    int unsigned low;
    low = int'(f3) % 4;
    if (low == 0) return 1;
    if (low == 1) return 2;
    return 4;
  endfunction

  function automatic logic [3:0] be_ref(input int unsigned sz, input int unsigned a);
    return 4'(((1 << sz) - 1) << a);
  endfunction

  function automatic logic [31:0] wdata_ref(input int unsigned sz, input logic [31:0] md);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = 8'(md >> (8 * (i % sz)));
    return r;
  endfunction

  function automatic logic [31:0] load_ref(input logic [2:0] f3, input int unsigned a,
                                           input logic [31:0] rd);
    logic [31:0]  w;
    int unsigned  v;
    w = rd >> (8 * a);
    case (f3)
      3'd0: begin v = w % 256;   return (v >= 128)   ? 32'(v) - 32'd256   : 32'(v); end
      3'd1: begin v = w % 65536; return (v >= 32768) ? 32'(v) - 32'd65536 : 32'(v); end
      3'd4: begin v = w % 256;   return 32'(v); end
      3'd5: begin v = w % 65536; return 32'(v); end
      default: return w;
    endcase
  endfunction

  task automatic check_all_zero(input string pfx);
    check_eq({pfx, "_stall"},       32'(stall), 32'd0);
    check_eq({pfx, "_dmem_req"},    32'(dmem_req), 32'd0);
    check_eq({pfx, "_dmem_we"},     32'(dmem_we), 32'd0);
    check_eq({pfx, "_dmem_be"},     32'(dmem_be), 32'd0);
    check_eq({pfx, "_dmem_addr"},   dmem_addr, 32'd0);
    check_eq({pfx, "_dmem_wdata"},  dmem_wdata, 32'd0);
    check_eq({pfx, "_wb_valid"},    32'(wb_valid), 32'd0);
    check_eq({pfx, "_control_out"}, {26'd0, control_out}, 32'd0);
    check_eq({pfx, "_wb_data"},     wb_data, 32'd0);
    check_eq({pfx, "_misaligned"},  32'(misaligned), 32'd0);
    check_eq({pfx, "_bus_error"},   32'(bus_error), 32'd0);
    check_eq({pfx, "_ex_mem_data"}, ex_mem_data, 32'd0);
  endtask

  task automatic idle_cycle();
    ex_valid    = 1'b0;
    control_in  = 6'($urandom);
    alu_data    = $urandom;
    memory_data = $urandom;
    dmem_gnt    = 1'b0;
    dmem_rvalid = 1'b0;
    @(posedge clk); #1;
    check_eq("idle_wb_valid",   32'(wb_valid), 32'd0);
    check_eq("idle_stall",      32'(stall), 32'd0);
    check_eq("idle_dmem_req",   32'(dmem_req), 32'd0);
    check_eq("idle_misaligned", 32'(misaligned), 32'd0);
    check_eq("idle_bus_error",  32'(bus_error), 32'd0);
  endtask

  // Issue one instruction and follow it to retirement. Called at posedge+1 with the stage idle;
  // returns at posedge+1 of the retire cycle so the next call can issue back-to-back.
  task automatic run_op(input control_t c, input logic [31:0] alu, input logic [31:0] md,
                        input int unsigned gnt_wait, input int unsigned rv_wait,
                        input logic [31:0] rd);
    int unsigned sz, a, k;
    logic        is_mem, is_load, mis, err, done;
    control_t    exp_ctl;
    sz      = size_of(c.funct3);
    a       = alu % 4;
    is_mem  = c.mem_read || c.mem_write;
    is_load = c.mem_read && !c.mem_write;
    mis     = is_mem && ((a % sz) != 0);
    err     = 1'b0;
    exp_ctl = c;

    check_eq("cap_stall", 32'(stall), 32'd0);
    ex_valid    = 1'b1;
    control_in  = c;
    alu_data    = alu;
    memory_data = md;
    @(posedge clk); #1;
    ex_valid    = 1'b0;
    control_in  = 6'($urandom);
    alu_data    = $urandom;
    memory_data = $urandom;
    check_eq("ex_mem_data", ex_mem_data, alu);

    if (is_mem && !mis) begin
      k = 0;
      done = 1'b0;
      while (!done) begin
        check_eq("req_dmem_req", 32'(dmem_req), 32'd1);
        check_eq("req_stall",    32'(stall), 32'd1);
        check_eq("req_wb_valid", 32'(wb_valid), 32'd0);
        check_eq("req_addr",     dmem_addr, alu & 32'hFFFF_FFFC);
        check_eq("req_we",       32'(dmem_we), 32'(c.mem_write));
        check_eq("req_be",       32'(dmem_be), 32'(be_ref(sz, a)));
        if (c.mem_write) check_eq("req_wdata", dmem_wdata, wdata_ref(sz, md));
        dmem_gnt   = (k == gnt_wait);
        ex_valid   = 1'($urandom);
        control_in = 6'($urandom);
        @(posedge clk); #1;
        dmem_gnt = 1'b0;
        ex_valid = 1'b0;
        if (k == gnt_wait) done = 1'b1;
        k++;
        if (!done && k == TO) begin
          err  = 1'b1;
          done = 1'b1;
        end
      end
      if (is_load && !err) begin
        k = 0;
        done = 1'b0;
        while (!done) begin
          check_eq("rsp_dmem_req", 32'(dmem_req), 32'd0);
          check_eq("rsp_stall",    32'(stall), 32'd1);
          check_eq("rsp_wb_valid", 32'(wb_valid), 32'd0);
          dmem_rvalid = (k == rv_wait);
          dmem_rdata  = (k == rv_wait) ? rd : $urandom;
          ex_valid    = 1'($urandom);
          control_in  = 6'($urandom);
          @(posedge clk); #1;
          dmem_rvalid = 1'b0;
          ex_valid    = 1'b0;
          if (k == rv_wait) done = 1'b1;
          k++;
          if (!done && k == TO) begin
            err  = 1'b1;
            done = 1'b1;
          end
        end
      end
    end

    if (mis || err) exp_ctl.reg_write = 1'b0;
    check_eq("ret_wb_valid",    32'(wb_valid), 32'd1);
    check_eq("ret_stall",       32'(stall), 32'd0);
    check_eq("ret_dmem_req",    32'(dmem_req), 32'd0);
    check_eq("ret_misaligned",  32'(misaligned), 32'(mis));
    check_eq("ret_bus_error",   32'(bus_error), 32'(err));
    check_eq("ret_control_out", {26'd0, control_out}, {26'd0, exp_ctl});
    if (!is_mem) check_eq("ret_wb_alu", wb_data, alu);
    if (is_load && !mis && !err) check_eq("ret_wb_load", wb_data, load_ref(c.funct3, a, rd));
  endtask

  initial begin
    int unsigned kind;
    logic [2:0]  f3;
    reset       = 1'b1;
    ex_valid    = 1'b0;
    control_in  = '0;
    alu_data    = '0;
    memory_data = '0;
    dmem_gnt    = 1'b0;
    dmem_rvalid = 1'b0;
    dmem_rdata  = '0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    reset = 1'b0;

    // Directed cases
    run_op(mk_ctl(1'b1, 1'b0, 1'b0, 3'd0), 32'h0000_1234, 32'h0, 0, 0, 32'h0);        // ADD
    idle_cycle();
    run_op(mk_ctl(1'b0, 1'b0, 1'b1, 3'd0), 32'h0000_0103, 32'h0000_00AB, 0, 0, 32'h0); // SB
    idle_cycle();
    run_op(mk_ctl(1'b1, 1'b1, 1'b0, 3'd0), 32'h0000_0102, 32'h0, 2, 2, 32'h0080_0000); // LB
    idle_cycle();
    run_op(mk_ctl(1'b1, 1'b1, 1'b0, 3'd5), 32'h0000_0101, 32'h0, 0, 0, 32'h0);        // LHU misaligned
    idle_cycle();
    run_op(mk_ctl(1'b1, 1'b1, 1'b0, 3'd2), 32'h0000_0300, 32'h0, NEVER, 0, 32'h0);    // LW timeout
    idle_cycle();

    // Reset while a load waits for rvalid; a late rvalid afterwards must be ignored.
    ex_valid   = 1'b1;
    control_in = mk_ctl(1'b1, 1'b1, 1'b0, 3'd2);
    alu_data   = 32'h0000_0200;
    @(posedge clk); #1;
    ex_valid = 1'b0;
    dmem_gnt = 1'b1;
    @(posedge clk); #1;
    dmem_gnt = 1'b0;
    check_eq("rst_rsp_stall", 32'(stall), 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check_all_zero("midrst");
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    dmem_rvalid = 1'b0;
    check_eq("late_rvalid_wb_valid", 32'(wb_valid), 32'd0);
    check_eq("late_rvalid_stall",    32'(stall), 32'd0);

    // Back-to-back: ADD issued in the LW retire cycle
    run_op(mk_ctl(1'b1, 1'b1, 1'b0, 3'd2), 32'h0000_0400, 32'h0, 1, 1, 32'h1234_5678);
    run_op(mk_ctl(1'b1, 1'b0, 1'b0, 3'd3), 32'h0000_5555, 32'h0, 0, 0, 32'h0);
    idle_cycle();

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      kind = $urandom_range(0, 2);
      if (kind == 0) begin
        run_op(mk_ctl(1'($urandom), 1'b0, 1'b0, 3'($urandom)), $urandom, $urandom, 0, 0, 32'h0);
      end else if (kind == 1) begin
        f3 = ld_f3[$urandom_range(0, 4)];
        run_op(mk_ctl(1'($urandom), 1'b1, 1'b0, f3), $urandom, $urandom,
               $urandom_range(0, 5), $urandom_range(0, 5), $urandom);
      end else begin
        f3 = 3'($urandom_range(0, 2));
        run_op(mk_ctl(1'($urandom), 1'b0, 1'b1, f3), $urandom, $urandom,
               $urandom_range(0, 5), 0, 32'h0);
      end
      if ($urandom_range(0, 3) == 0) idle_cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
